rr_mux_2_1_arb: RTL

- Two-channel packet arbiter that sits directly upstream of the 2:1 mux datapath. It generates the mux select and registers the muxed stream.
- Accepts two valid/ready input streams (A, B). Arbitrates round-robin at packet granularity, holding the grant until the beat carrying last is accepted.
- Presents one registered output stream plus the select that produced each output beat.

---
 rtl/rr_mux_2_1_arb.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rr_mux_2_1_arb.sv
// Two-channel round-robin packet arbiter feeding a registered 2:1 mux output stage.
// Optional per-channel accepted-beat counters are enabled with RR_MUX_2_1_ARB_CNT_EN.
module rr_mux_2_1_arb #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [DATA_W-1:0] y_data,
  output logic              y_last,
  output logic              select,
  output logic [CNT_W-1:0]  a_cnt,
  output logic [CNT_W-1:0]  b_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                y_valid_q;
  logic [DATA_W-1:0]   y_data_q;
  logic                y_last_q;
  logic                sel_q;

  logic                load_c;
  logic                a_rdy_c, b_rdy_c;
  logic                a_xfer_c, b_xfer_c, xfer_c;
  logic [DATA_W-1:0]   xfer_data_c;
  logic                xfer_last_c;

  // Output register can accept a new beat when empty or draining this cycle.
  assign load_c = !y_valid_q || y_ready;

  // Arbitration, ready generation and packet lock tracking.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_rdy_c      = 1'b0;
    b_rdy_c      = 1'b0;
    a_xfer_c     = 1'b0;
    b_xfer_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_c) begin
          // On a tie the channel that did not win last time is picked.
          if (a_valid && (!b_valid || last_grant_q)) begin
            a_rdy_c = 1'b1;
          end else if (b_valid) begin
            b_rdy_c = 1'b1;
          end
        end
      end
      LOCK_A: a_rdy_c = load_c;
      LOCK_B: b_rdy_c = load_c;
      default: state_d = IDLE;
    endcase

    a_xfer_c = a_valid && a_rdy_c && !rst;
    b_xfer_c = b_valid && b_rdy_c && !rst;

    if (a_xfer_c) begin
      if (a_last) begin
        state_d      = IDLE;
        last_grant_d = 1'b0;
      end else begin
        state_d = LOCK_A;
      end
    end else if (b_xfer_c) begin
      if (b_last) begin
        state_d      = IDLE;
        last_grant_d = 1'b1;
      end else begin
        state_d = LOCK_B;
      end
    end
  end

  assign xfer_c      = a_xfer_c || b_xfer_c;
  assign xfer_data_c = b_xfer_c ? b_data : a_data;
  assign xfer_last_c = b_xfer_c ? b_last : a_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Registered mux output stage; payload holds when nothing is transferred.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_last_q  <= 1'b0;
      sel_q     <= 1'b0;
    end else if (xfer_c) begin
      y_valid_q <= 1'b1;
      y_data_q  <= xfer_data_c;
      y_last_q  <= xfer_last_c;
      sel_q     <= b_xfer_c;
    end else if (load_c) begin
      y_valid_q <= 1'b0;
    end
  end

  assign a_ready = a_rdy_c && !rst;
  assign b_ready = b_rdy_c && !rst;
  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_last  = y_last_q;
  assign select  = sel_q;

`ifdef RR_MUX_2_1_ARB_CNT_EN
  logic [CNT_W-1:0] a_cnt_q, b_cnt_q;

  // Saturating accepted-beat counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      if (a_xfer_c && (a_cnt_q != {CNT_W{1'b1}})) begin
        a_cnt_q <= a_cnt_q + CNT_W'(1);
      end
      if (b_xfer_c && (b_cnt_q != {CNT_W{1'b1}})) begin
        b_cnt_q <= b_cnt_q + CNT_W'(1);
      end
    end
  end

  assign a_cnt = a_cnt_q;
  assign b_cnt = b_cnt_q;
`else
  assign a_cnt = '0;
  assign b_cnt = '0;
`endif

endmodule
